// File: rtl/pad_in_filter.sv
// Core-side pad receiver: per-pad synchroniser, glitch filter and edge detect,
// with sticky pending edges drained one at a time over a valid/ready event port.
module pad_in_filter #(
  parameter int NPads    = 16,
  parameter int CntWidth = 4,
  localparam int IdxW    = (NPads > 1) ? $clog2(NPads) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NPads-1:0]    pad_in_i,
  input  logic [NPads-1:0]    filter_en_i,
  input  logic [CntWidth-1:0] filter_thr_i,
  input  logic [NPads-1:0]    evt_en_i,
  output logic [NPads-1:0]    in_o,
  output logic [NPads-1:0]    rise_o,
  output logic [NPads-1:0]    fall_o,
  output logic                event_valid_o,
  input  logic                event_ready_i,
  output logic [IdxW-1:0]     event_idx_o,
  output logic                event_level_o,
  output logic                overflow_o,
  input  logic                clr_overflow_i
);

  logic [NPads-1:0]    sync1_q;
  logic [NPads-1:0]    sync_q;
  logic [NPads-1:0]    filt_q;
  logic [NPads-1:0]    prev_q;
  logic [CntWidth-1:0] cnt_q [NPads];
  logic [NPads-1:0]    pend_q;
  logic                event_valid_q;
  logic [IdxW-1:0]     event_idx_q;
  logic                event_level_q;
  logic                overflow_q;

  logic [NPads-1:0]    edge_evt;
  logic                load;
  logic                pick_found;
  logic [IdxW-1:0]     pick_idx;
  logic [NPads-1:0]    clr_mask;
  logic                ovf_set;

  assign in_o          = filt_q;
  assign rise_o        = filt_q & ~prev_q;
  assign fall_o        = ~filt_q & prev_q;
  assign event_valid_o = event_valid_q;
  assign event_idx_o   = event_idx_q;
  assign event_level_o = event_level_q;
  assign overflow_o    = overflow_q;

  assign edge_evt = (rise_o | fall_o) & evt_en_i;
  assign load     = !event_valid_q || event_ready_i;

  // Lowest-index pending pad wins
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NPads - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        pick_found = 1'b1;
        pick_idx   = IdxW'(k);
      end
    end
  end

  assign clr_mask = (load && pick_found) ? (NPads'(1) << pick_idx) : '0;
  assign ovf_set  = |(edge_evt & pend_q & ~clr_mask);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync_q  <= '0;
      filt_q  <= '0;
      prev_q  <= '0;
      for (int k = 0; k < NPads; k++) cnt_q[k] <= '0;
    end else begin
      sync1_q <= pad_in_i;
      sync_q  <= sync1_q;
      prev_q  <= filt_q;
      for (int k = 0; k < NPads; k++) begin
        if (!filter_en_i[k] || filter_thr_i == '0) begin
          filt_q[k] <= sync_q[k];
          cnt_q[k]  <= '0;
        end else if (sync_q[k] == filt_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] >= filter_thr_i) begin
          // '>=' lets a threshold lowered below the running count commit at once
          filt_q[k] <= sync_q[k];
          cnt_q[k]  <= '0;
        end else begin
          cnt_q[k] <= cnt_q[k] + CntWidth'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q        <= '0;
      event_valid_q <= 1'b0;
      event_idx_q   <= '0;
      event_level_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      // A new edge on the pad being handed out keeps its pending bit set
      pend_q <= (pend_q & ~clr_mask) | edge_evt;
      if (load) begin
        event_valid_q <= pick_found;
        if (pick_found) begin
          event_idx_q   <= pick_idx;
          event_level_q <= filt_q[pick_idx];
        end
      end
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (clr_overflow_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pad_in_filter.sv
// Directed bench for pad_in_filter: bypass, filtering, event ordering,
// overflow, reset mid-operation and live threshold change.
module tb_pad_in_filter;

  localparam int NPads    = 16;
  localparam int CntWidth = 4;
  localparam int IdxW     = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [NPads-1:0]    pad_in_i;
  logic [NPads-1:0]    filter_en_i;
  logic [CntWidth-1:0] filter_thr_i;
  logic [NPads-1:0]    evt_en_i;
  logic [NPads-1:0]    in_o;
  logic [NPads-1:0]    rise_o;
  logic [NPads-1:0]    fall_o;
  logic                event_valid_o;
  logic                event_ready_i;
  logic [IdxW-1:0]     event_idx_o;
  logic                event_level_o;
  logic                overflow_o;
  logic                clr_overflow_i;

  int n_vec = 0;
  int n_err = 0;

  pad_in_filter #(.NPads(NPads), .CntWidth(CntWidth)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .pad_in_i       (pad_in_i),
    .filter_en_i    (filter_en_i),
    .filter_thr_i   (filter_thr_i),
    .evt_en_i       (evt_en_i),
    .in_o           (in_o),
    .rise_o         (rise_o),
    .fall_o         (fall_o),
    .event_valid_o  (event_valid_o),
    .event_ready_i  (event_ready_i),
    .event_idx_o    (event_idx_o),
    .event_level_o  (event_level_o),
    .overflow_o     (overflow_o),
    .clr_overflow_i (clr_overflow_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    pad_in_i       = '0;
    filter_en_i    = '0;
    filter_thr_i   = '0;
    evt_en_i       = '0;
    event_ready_i  = 1'b0;
    clr_overflow_i = 1'b0;
    rst_ni         = 1'b0;
    tick(3);
    rst_ni = 1'b1;
  endtask

  initial begin
    // 1: bypass (filter off on pad0, thr=0 on pad9), reset state
    do_reset();
    chk("rst_in", in_o, 0);
    chk("rst_valid", event_valid_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_rise", rise_o, 0);
    filter_en_i = 16'h0200;
    pad_in_i    = 16'h0201;
    tick(2);
    chk("byp_in_c2", in_o, 16'h0000);
    tick(1);
    chk("byp_in_c3", in_o, 16'h0201);
    chk("byp_rise_c3", rise_o, 16'h0201);
    tick(1);
    chk("byp_rise_c4", rise_o, 16'h0000);
    chk("byp_in_c4", in_o, 16'h0201);

    // 2: glitch filter thr=3 on pad1
    do_reset();
    filter_thr_i = 4'd3;
    filter_en_i  = 16'h0002;
    pad_in_i     = 16'h0002;
    tick(3);
    pad_in_i = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("flt_short", in_o, 0);
    end
    pad_in_i = 16'h0002;
    tick(4);
    pad_in_i = 16'h0000;
    tick(1);
    chk("flt_c5", in_o, 16'h0000);
    tick(1);
    chk("flt_c6", in_o, 16'h0002);
    chk("flt_rise", rise_o, 16'h0002);
    tick(3);
    chk("flt_c9", in_o, 16'h0002);
    tick(1);
    chk("flt_c10", in_o, 16'h0000);
    chk("flt_fall", fall_o, 16'h0002);

    // 3: simultaneous edges on pads 5 and 2, lowest index first
    do_reset();
    evt_en_i = 16'hFFFF;
    pad_in_i = 16'h0024;
    tick(4);
    chk("ord_c4_valid", event_valid_o, 0);
    tick(1);
    chk("ord_valid", event_valid_o, 1);
    chk("ord_idx2", event_idx_o, 2);
    chk("ord_lvl2", event_level_o, 1);
    tick(3);
    chk("ord_hold_valid", event_valid_o, 1);
    chk("ord_hold_idx", event_idx_o, 2);
    event_ready_i = 1'b1;
    tick(1);
    chk("ord_next_valid", event_valid_o, 1);
    chk("ord_idx5", event_idx_o, 5);
    chk("ord_lvl5", event_level_o, 1);
    tick(1);
    chk("ord_empty", event_valid_o, 0);
    event_ready_i = 1'b0;

    // 4: overflow on pad3, clear, disabled pad produces nothing
    do_reset();
    evt_en_i = 16'hFFFF;
    pad_in_i = 16'h0008;
    tick(2);
    pad_in_i = 16'h0000;
    tick(2);
    pad_in_i = 16'h0008;
    tick(1);
    chk("ovf_evt_valid", event_valid_o, 1);
    chk("ovf_evt_idx", event_idx_o, 3);
    chk("ovf_evt_lvl", event_level_o, 1);
    tick(2);
    chk("ovf_c7", overflow_o, 0);
    tick(1);
    chk("ovf_c8", overflow_o, 1);
    tick(2);
    chk("ovf_sticky", overflow_o, 1);
    chk("ovf_hold_idx", event_idx_o, 3);
    clr_overflow_i = 1'b1;
    tick(1);
    clr_overflow_i = 1'b0;
    chk("ovf_clr", overflow_o, 0);
    event_ready_i = 1'b1;
    tick(1);
    chk("ovf_drain_valid", event_valid_o, 1);
    chk("ovf_drain_idx", event_idx_o, 3);
    chk("ovf_drain_lvl", event_level_o, 1);
    tick(1);
    chk("ovf_drain_empty", event_valid_o, 0);
    event_ready_i = 1'b0;
    evt_en_i = 16'hFFF7;
    pad_in_i = 16'h0000;
    tick(6);
    chk("dis_in", in_o, 0);
    chk("dis_valid", event_valid_o, 0);
    chk("dis_ovf", overflow_o, 0);

    // 5: reset while counting and while an event is presented
    do_reset();
    filter_thr_i = 4'd5;
    filter_en_i  = 16'hFFBF;
    evt_en_i     = 16'h0040;
    pad_in_i     = 16'h0040;
    tick(1);
    pad_in_i = 16'h00C0;
    tick(4);
    chk("mid_valid", event_valid_o, 1);
    chk("mid_idx", event_idx_o, 6);
    chk("mid_in", in_o, 16'h0040);
    rst_ni   = 1'b0;
    evt_en_i = 16'h0000;
    tick(1);
    chk("mrst_in", in_o, 0);
    chk("mrst_valid", event_valid_o, 0);
    chk("mrst_idx", event_idx_o, 0);
    chk("mrst_lvl", event_level_o, 0);
    chk("mrst_ovf", overflow_o, 0);
    chk("mrst_edges", rise_o | fall_o, 0);
    rst_ni = 1'b1;
    tick(2);
    chk("rel_c2", in_o, 16'h0000);
    tick(1);
    chk("rel_c3", in_o, 16'h0040);
    tick(4);
    chk("rel_c7", in_o, 16'h0040);
    chk("rel_valid", event_valid_o, 0);
    tick(1);
    chk("rel_c8", in_o, 16'h00C0);

    // 6: threshold lowered below running count commits next cycle
    do_reset();
    filter_thr_i = 4'd7;
    filter_en_i  = 16'h0100;
    pad_in_i     = 16'h0100;
    tick(6);
    chk("thr_c6", in_o, 16'h0000);
    filter_thr_i = 4'd1;
    tick(1);
    chk("thr_c7", in_o, 16'h0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
